// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle ALU control block: op classes,
// R-format function codes, ALU control codes and FSM state encoding.
package alu_ctrl_pkg;

    // Main-control ALU op classes
    localparam logic [2:0] OP_RTYPE = 3'b100;
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_LUI   = 3'b111;
    localparam logic [2:0] OP_SUB   = 3'b010;

    // R-format function field codes
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;
    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SLLV  = 6'd4;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    // ALU control encodings
    localparam logic [3:0] CTRL_ADD   = 4'b0000;
    localparam logic [3:0] CTRL_SUB   = 4'b0010;
    localparam logic [3:0] CTRL_AND   = 4'b0100;
    localparam logic [3:0] CTRL_OR    = 4'b0101;
    localparam logic [3:0] CTRL_MULTU = 4'b0110;
    localparam logic [3:0] CTRL_DIVU  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU  = 4'b1011;
    localparam logic [3:0] CTRL_SLT   = 4'b1010;
    localparam logic [3:0] CTRL_SLLV  = 4'b1100;
    localparam logic [3:0] CTRL_SLL   = 4'b1101;
    localparam logic [3:0] CTRL_LUI   = 4'b1111;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_ITER   = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of ALUOp/funct into an ALU control code plus
// multi-cycle and illegal flags.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] ALUOp_i,
    input  logic [5:0] funct_i,
    output logic [3:0] code_o,
    output logic       multi_o,
    output logic       illegal_o
);

    // Decode op class first; R-format defers to the function field
    always_comb begin
        code_o    = CTRL_ADD;
        multi_o   = 1'b0;
        illegal_o = 1'b0;
        case (ALUOp_i)
            OP_ADD: code_o = CTRL_ADD;
            OP_SUB: code_o = CTRL_SUB;
            OP_OR:  code_o = CTRL_OR;
            OP_LUI: code_o = CTRL_LUI;
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:   code_o = CTRL_ADD;
                    FN_SUB:   code_o = CTRL_SUB;
                    FN_AND:   code_o = CTRL_AND;
                    FN_OR:    code_o = CTRL_OR;
                    FN_SLT:   code_o = CTRL_SLT;
                    FN_SLTU:  code_o = CTRL_SLTU;
                    FN_SLL:   code_o = CTRL_SLL;
                    FN_SLLV:  code_o = CTRL_SLLV;
                    FN_MULTU: begin
                        code_o  = CTRL_MULTU;
                        multi_o = 1'b1;
                    end
                    FN_DIVU: begin
                        code_o  = CTRL_DIVU;
                        multi_o = 1'b1;
                    end
                    default:  illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// Multi-cycle ALU control: decodes a request into a registered ALU
// control code and sequences single-cycle or DATA_W-step operations.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DATA_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [5:0]       funct_i,
    input  logic [2:0]       ALUOp_i,
    input  logic             flush_i,
    output logic [3:0]       ALUCtrl_o,
    output logic             busy_o,
    output logic             step_o,
    output logic [CNT_W-1:0] step_idx_o,
    output logic             done_o,
    output logic             illegal_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_ctrl;
    logic [3:0]       w_ctrl_nxt;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_nxt;
    logic             r_ill_pend;
    logic             w_ill_pend_nxt;
    logic             r_busy;
    logic             r_step;
    logic             r_done;
    logic             r_illegal;
    logic             w_done_nxt;
    logic             w_illegal_nxt;

    logic [3:0]       w_dec_code;
    logic             w_dec_multi;
    logic             w_dec_illegal;

    alu_ctrl_dec u_dec (
        .ALUOp_i   (ALUOp_i),
        .funct_i   (funct_i),
        .code_o    (w_dec_code),
        .multi_o   (w_dec_multi),
        .illegal_o (w_dec_illegal)
    );

    // State, code, counter and all status outputs are registered together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= CTRL_ADD;
            r_idx      <= '0;
            r_ill_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_step     <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_idx      <= w_idx_nxt;
            r_ill_pend <= w_ill_pend_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_step     <= (w_state_nxt == ST_ITER);
            r_done     <= w_done_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    // Next-state logic; flush overrides everything, including a new request
    always_comb begin
        w_state_nxt    = r_state;
        w_ctrl_nxt     = r_ctrl;
        w_idx_nxt      = r_idx;
        w_ill_pend_nxt = r_ill_pend;
        w_done_nxt     = 1'b0;
        w_illegal_nxt  = 1'b0;
        if (flush_i) begin
            w_state_nxt    = ST_IDLE;
            w_idx_nxt      = '0;
            w_ill_pend_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        w_idx_nxt = '0;
                        if (w_dec_illegal) begin
                            // Illegal ops keep the previous code, finish as single-cycle
                            w_state_nxt    = ST_SINGLE;
                            w_ill_pend_nxt = 1'b1;
                        end else begin
                            w_ctrl_nxt     = w_dec_code;
                            w_ill_pend_nxt = 1'b0;
                            w_state_nxt    = w_dec_multi ? ST_ITER : ST_SINGLE;
                        end
                    end
                end
                ST_SINGLE: begin
                    w_state_nxt    = ST_IDLE;
                    w_done_nxt     = 1'b1;
                    w_illegal_nxt  = r_ill_pend;
                    w_ill_pend_nxt = 1'b0;
                end
                ST_ITER: begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign ALUCtrl_o  = r_ctrl;
    assign busy_o     = r_busy;
    assign step_o     = r_step;
    assign step_idx_o = r_idx;
    assign done_o     = r_done;
    assign illegal_o  = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc with DATA_W=8.
module tb_alu_ctrl_mc;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_i;
    logic [5:0]       funct_i;
    logic [2:0]       ALUOp_i;
    logic             flush_i;
    logic [3:0]       ALUCtrl_o;
    logic             busy_o;
    logic             step_o;
    logic [CNT_W-1:0] step_idx_o;
    logic             done_o;
    logic             illegal_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_ctrl_mc #(.DATA_W(DATA_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .funct_i    (funct_i),
        .ALUOp_i    (ALUOp_i),
        .flush_i    (flush_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .busy_o     (busy_o),
        .step_o     (step_o),
        .step_idx_o (step_idx_o),
        .done_o     (done_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy_o), 32'd0);
        chk({tag, ".step"}, 32'(step_o), 32'd0);
        chk({tag, ".idx"}, 32'(step_idx_o), 32'd0);
        chk({tag, ".done"}, 32'(done_o), 32'd0);
        chk({tag, ".illegal"}, 32'(illegal_o), 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [5:0] fn);
        req_i   = 1'b1;
        ALUOp_i = op;
        funct_i = fn;
        tick();
        req_i   = 1'b0;
    endtask

    // Single-cycle op table: ALUOp, funct, expected code
    logic [2:0] t_op  [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b111, 3'b101};
    logic [5:0] t_fn  [6] = '{6'd36,  6'd42,  6'd43,  6'd0,   6'd9,   6'd0};
    logic [3:0] t_exp [6] = '{4'b0100, 4'b1010, 4'b1011, 4'b1101, 4'b1111, 4'b0101};

    initial begin
        rst_i   = 1'b1;
        req_i   = 1'b0;
        funct_i = 6'd0;
        ALUOp_i = 3'b000;
        flush_i = 1'b0;
        tick();
        tick();
        chk("rst.ctrl", 32'(ALUCtrl_o), 32'h0);
        chk_idle_zero("rst");
        #3 rst_i = 1'b0;
        tick();

        // R-format SUB: code after accepting edge, busy one cycle, done next
        issue(3'b100, 6'd34);
        chk("sub.ctrl", 32'(ALUCtrl_o), 32'b0010);
        chk("sub.busy", 32'(busy_o), 32'd1);
        chk("sub.done0", 32'(done_o), 32'd0);
        tick();
        chk("sub.done1", 32'(done_o), 32'd1);
        chk("sub.busy1", 32'(busy_o), 32'd0);
        chk("sub.ill1", 32'(illegal_o), 32'd0);
        tick();
        chk("sub.done2", 32'(done_o), 32'd0);

        // Illegal op class keeps previous code
        issue(3'b011, 6'd32);
        chk("ill.busy", 32'(busy_o), 32'd1);
        chk("ill.ctrl0", 32'(ALUCtrl_o), 32'b0010);
        tick();
        chk("ill.done", 32'(done_o), 32'd1);
        chk("ill.illegal", 32'(illegal_o), 32'd1);
        chk("ill.ctrl1", 32'(ALUCtrl_o), 32'b0010);
        tick();
        chk("ill.done2", 32'(done_o), 32'd0);
        chk("ill.illegal2", 32'(illegal_o), 32'd0);

        // MULTU: DATA_W steps; a request during busy is ignored
        issue(3'b100, 6'd25);
        for (int i = 0; i < DATA_W; i++) begin
            chk($sformatf("mul.step%0d", i), 32'(step_o), 32'd1);
            chk($sformatf("mul.idx%0d", i), 32'(step_idx_o), 32'(i));
            chk($sformatf("mul.done%0d", i), 32'(done_o), 32'd0);
            chk($sformatf("mul.ctrl%0d", i), 32'(ALUCtrl_o), 32'b0110);
            if (i == 2) begin
                req_i   = 1'b1;
                ALUOp_i = 3'b100;
                funct_i = 6'd34;
            end else begin
                req_i = 1'b0;
            end
            tick();
        end
        chk("mul.fin.step", 32'(step_o), 32'd0);
        chk("mul.fin.done", 32'(done_o), 32'd1);
        chk("mul.fin.busy", 32'(busy_o), 32'd1);
        tick();
        chk("mul.after.done", 32'(done_o), 32'd0);
        chk("mul.after.busy", 32'(busy_o), 32'd0);
        chk("mul.after.ctrl", 32'(ALUCtrl_o), 32'b0110);
        tick();
        chk("mul.nodup.done", 32'(done_o), 32'd0);
        chk("mul.nodup.busy", 32'(busy_o), 32'd0);

        // Back-to-back: ADD then OR issued in the done cycle
        issue(3'b000, 6'd5);
        chk("add.ctrl", 32'(ALUCtrl_o), 32'b0000);
        tick();
        chk("add.done", 32'(done_o), 32'd1);
        issue(3'b101, 6'd0);
        chk("b2b.ctrl", 32'(ALUCtrl_o), 32'b0101);
        chk("b2b.busy", 32'(busy_o), 32'd1);
        tick();
        chk("b2b.done", 32'(done_o), 32'd1);
        tick();

        // Table of remaining single-cycle decodes
        for (int k = 0; k < 6; k++) begin
            issue(t_op[k], t_fn[k]);
            chk($sformatf("tbl%0d.ctrl", k), 32'(ALUCtrl_o), 32'(t_exp[k]));
            tick();
            chk($sformatf("tbl%0d.done", k), 32'(done_o), 32'd1);
            tick();
        end

        // Illegal funct under R-format holds OR code
        issue(3'b100, 6'd1);
        tick();
        chk("illfn.illegal", 32'(illegal_o), 32'd1);
        chk("illfn.ctrl", 32'(ALUCtrl_o), 32'b0101);
        tick();

        // DIVU flushed at step index 3
        issue(3'b100, 6'd27);
        tick();
        tick();
        tick();
        chk("div.idx3", 32'(step_idx_o), 32'd3);
        chk("div.ctrl", 32'(ALUCtrl_o), 32'b0111);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk_idle_zero("flush");
        chk("flush.ctrl", 32'(ALUCtrl_o), 32'b0111);
        tick();
        chk("flush.nodone", 32'(done_o), 32'd0);

        // Flush wins over a simultaneous request in IDLE
        req_i   = 1'b1;
        flush_i = 1'b1;
        ALUOp_i = 3'b100;
        funct_i = 6'd32;
        tick();
        req_i   = 1'b0;
        flush_i = 1'b0;
        chk("drop.busy", 32'(busy_o), 32'd0);
        chk("drop.ctrl", 32'(ALUCtrl_o), 32'b0111);
        tick();
        chk("drop.done", 32'(done_o), 32'd0);

        // Asynchronous reset in the middle of ITER
        issue(3'b100, 6'd25);
        tick();
        tick();
        chk("ar.pre.idx", 32'(step_idx_o), 32'd2);
        #2 rst_i = 1'b1;
        #1;
        chk("ar.ctrl", 32'(ALUCtrl_o), 32'h0);
        chk_idle_zero("ar");
        tick();
        #2 rst_i = 1'b0;
        // First edge after release accepts a request
        req_i   = 1'b1;
        ALUOp_i = 3'b100;
        funct_i = 6'd42;
        tick();
        req_i = 1'b0;
        chk("rel.ctrl", 32'(ALUCtrl_o), 32'b1010);
        chk("rel.busy", 32'(busy_o), 32'd1);
        chk("rel.step", 32'(step_o), 32'd0);
        tick();
        chk("rel.done", 32'(done_o), 32'd1);
        tick();
        chk("rel.done2", 32'(done_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
